// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the 32-bit-to-16-bit SRAM access controller.
package mem_ctrl_pkg;

  localparam int unsigned WAIT_CYCLES_DEF = 1;
  localparam int unsigned SRAM_AW         = 18;
  localparam int unsigned CNT_W           = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Halfword address: the word index with the half select appended as the LSB.
  function automatic logic [SRAM_AW-1:0] half_addr(input logic [15:0] word_idx, input logic hi);
    half_addr = {1'b0, word_idx, hi};
  endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Pipeline-side request/response signals plus the 16-bit SRAM pins.
interface mem_access_controller_if;
  import mem_ctrl_pkg::*;

  logic               MEM_R_EN;
  logic               MEM_W_EN;
  logic [31:0]        address;
  logic [31:0]        writeData;
  logic [31:0]        readData;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_wdata;
  logic [15:0]        sram_rdata;
  logic               sram_we_n;
  logic               sram_oe_n;

  modport master (
    output MEM_R_EN, MEM_W_EN, address, writeData, sram_rdata,
    input  readData, ready, sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, writeData, sram_rdata,
    output readData, ready, sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );

endinterface

// File: rtl/mem_access_controller_wait_counter.sv
// Phase timer: counts cycles within an SRAM phase and flags the last one.
module wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign done_o = (count_q == CNT_W'(LIMIT));

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (enable_i) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_controller.sv
// Splits each 32-bit load/store into a low and a high 16-bit SRAM phase,
// stalling the pipeline through ready until the access finishes.
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input logic                    clk,
  input logic                    rst,
  mem_access_controller_if.slave bus
);

  state_e             state_q, state_d;
  logic               op_wr_q, op_wr_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        sram_wdata_q, sram_wdata_d;
  logic               sram_we_n_q, sram_we_n_d;
  logic               sram_oe_n_q, sram_oe_n_d;
  logic               req_s;
  logic               in_phase_s;
  logic               phase_done_s;
  logic               ready_s;
  logic               unused_addr_s;

  assign req_s         = bus.MEM_R_EN | bus.MEM_W_EN;
  assign in_phase_s    = (state_q == ST_LO) || (state_q == ST_HI);
  assign unused_addr_s = ^{bus.address[31:18], bus.address[1:0]};

  wait_counter #(.LIMIT(WAIT_CYCLES)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!in_phase_s || phase_done_s),
    .enable_i (in_phase_s),
    .done_o   (phase_done_s)
  );

  // Next state; the operation type is latched once so mid-access enable changes are ignored.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d = ST_LO;
          op_wr_d = bus.MEM_W_EN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LO: begin
        if (phase_done_s) state_d = ST_HI;
        else              state_d = ST_LO;
      end
      ST_HI: begin
        if (phase_done_s) state_d = ST_DONE;
        else              state_d = ST_HI;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // SRAM pin values for the upcoming cycle, decoded from the next state so the pins are registered.
  always_comb begin
    sram_addr_d  = {SRAM_AW{1'b0}};
    sram_wdata_d = 16'h0000;
    sram_we_n_d  = 1'b1;
    sram_oe_n_d  = 1'b1;
    case (state_d)
      ST_LO: begin
        sram_addr_d = half_addr(bus.address[17:2], 1'b0);
        if (op_wr_d) begin
          sram_wdata_d = bus.writeData[15:0];
          sram_we_n_d  = 1'b0;
        end else begin
          sram_oe_n_d  = 1'b0;
        end
      end
      ST_HI: begin
        sram_addr_d = half_addr(bus.address[17:2], 1'b1);
        if (op_wr_d) begin
          sram_wdata_d = bus.writeData[31:16];
          sram_we_n_d  = 1'b0;
        end else begin
          sram_oe_n_d  = 1'b0;
        end
      end
      default: begin
        sram_addr_d  = {SRAM_AW{1'b0}};
        sram_wdata_d = 16'h0000;
        sram_we_n_d  = 1'b1;
        sram_oe_n_d  = 1'b1;
      end
    endcase
  end

  // Read capture on the final cycle of each phase; the SRAM data is valid by then.
  always_comb begin
    read_data_d = read_data_q;
    if (!op_wr_q && phase_done_s && (state_q == ST_LO)) begin
      read_data_d[15:0] = bus.sram_rdata;
    end else if (!op_wr_q && phase_done_s && (state_q == ST_HI)) begin
      read_data_d[31:16] = bus.sram_rdata;
    end else begin
      read_data_d = read_data_q;
    end
  end

  // ready is combinational so it drops in the same cycle a request appears.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ST_DONE: ready_s = 1'b1;
      ST_IDLE: ready_s = !req_s;
      default: ready_s = 1'b0;
    endcase
  end

  // State, operation type, read data and SRAM pin registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      op_wr_q      <= 1'b0;
      read_data_q  <= 32'h0000_0000;
      sram_addr_q  <= {SRAM_AW{1'b0}};
      sram_wdata_q <= 16'h0000;
      sram_we_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_wr_q      <= op_wr_d;
      read_data_q  <= read_data_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_oe_n_q  <= sram_oe_n_d;
    end
  end

  assign bus.ready      = ready_s;
  assign bus.readData   = read_data_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign bus.sram_we_n  = sram_we_n_q;
  assign bus.sram_oe_n  = sram_oe_n_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench: two controllers (WAIT_CYCLES=1 and 0), each with a small SRAM model.
module tb_mem_access_controller;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_controller_if bus_a ();
  mem_access_controller_if bus_b ();

  mem_access_controller #(.WAIT_CYCLES(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  mem_access_controller #(.WAIT_CYCLES(0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  logic [15:0] sram_a [256];
  logic [15:0] sram_b [256];

  always @(posedge clk) if (!bus_a.sram_we_n) sram_a[bus_a.sram_addr[7:0]] <= bus_a.sram_wdata;
  always @(posedge clk) if (!bus_b.sram_we_n) sram_b[bus_b.sram_addr[7:0]] <= bus_b.sram_wdata;
  assign bus_a.sram_rdata = bus_a.sram_oe_n ? 16'h0000 : sram_a[bus_a.sram_addr[7:0]];
  assign bus_b.sram_rdata = bus_b.sram_oe_n ? 16'h0000 : sram_b[bus_b.sram_addr[7:0]];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] ref_mem [2][256];
  logic [31:0] exp_rd  [2];
  logic [31:0] sb_q [$];

  task automatic drive(input int inst, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (inst == 0) begin
      bus_a.MEM_R_EN = r; bus_a.MEM_W_EN = w; bus_a.address = a; bus_a.writeData = d;
    end else begin
      bus_b.MEM_R_EN = r; bus_b.MEM_W_EN = w; bus_b.address = a; bus_b.writeData = d;
    end
  endtask

  task automatic sample(input int inst, output logic rdy, output logic we_n, output logic oe_n,
                        output logic [17:0] ad, output logic [15:0] wd, output logic [31:0] rd);
    if (inst == 0) begin
      rdy = bus_a.ready; we_n = bus_a.sram_we_n; oe_n = bus_a.sram_oe_n;
      ad = bus_a.sram_addr; wd = bus_a.sram_wdata; rd = bus_a.readData;
    end else begin
      rdy = bus_b.ready; we_n = bus_b.sram_we_n; oe_n = bus_b.sram_oe_n;
      ad = bus_b.sram_addr; wd = bus_b.sram_wdata; rd = bus_b.readData;
    end
  endtask

  // One full access with per-cycle checks; flip swaps the enables after the first LO cycle.
  task automatic run_access(input int inst, input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input bit keep, input bit flip, input string tag);
    int          wt;
    int          last;
    logic        rdy, we_n, oe_n;
    logic [17:0] ad;
    logic [15:0] wd;
    logic [31:0] rd;
    logic [31:0] exp;
    logic [17:0] exp_ad;
    logic        hi;
    logic [15:0] half;
    wt   = (inst == 0) ? 1 : 0;
    last = 1 + 2 * (wt + 1);
    if (w) begin
      ref_mem[inst][{a[8:2], 1'b0}] = d[15:0];
      ref_mem[inst][{a[8:2], 1'b1}] = d[31:16];
    end else begin
      exp_rd[inst] = {ref_mem[inst][{a[8:2], 1'b1}], ref_mem[inst][{a[8:2], 1'b0}]};
    end
    sb_q.push_back(exp_rd[inst]);
    @(negedge clk);
    drive(inst, r, w, a, d);
    #1;
    sample(inst, rdy, we_n, oe_n, ad, wd, rd);
    n_tests++;
    if (rdy !== 1'b0 || we_n !== 1'b1 || oe_n !== 1'b1) begin
      n_fail++;
      $display("FAIL %s req_cycle: ready=%b we_n=%b oe_n=%b, expected 0/1/1", tag, rdy, we_n, oe_n);
    end
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      #1;
      sample(inst, rdy, we_n, oe_n, ad, wd, rd);
      n_tests++;
      if (c < last) begin
        hi     = (c > wt + 1) ? 1'b1 : 1'b0;
        half   = hi ? d[31:16] : d[15:0];
        exp_ad = {1'b0, a[17:2], hi};
        if (rdy !== 1'b0 || ad !== exp_ad || we_n !== !w || oe_n !== w || (w && wd !== half)) begin
          n_fail++;
          $display("FAIL %s cycle%0d: ready=%b addr=%h we_n=%b oe_n=%b wdata=%h, expected 0/%h/%b/%b/%h",
                   tag, c, rdy, ad, we_n, oe_n, wd, exp_ad, !w, w, half);
        end
      end else begin
        exp = sb_q.pop_front();
        if (rdy !== 1'b1 || we_n !== 1'b1 || oe_n !== 1'b1 || ad !== 18'h0 || wd !== 16'h0 || rd !== exp) begin
          n_fail++;
          $display("FAIL %s done_cycle%0d: ready=%b we_n=%b oe_n=%b addr=%h wdata=%h readData=%h, expected 1/1/1/0/0/%h",
                   tag, c, rdy, we_n, oe_n, ad, wd, rd, exp);
        end
      end
      if (flip && c == 1) drive(inst, w, r, a, d);
    end
    if (!keep) drive(inst, 1'b0, 1'b0, a, d);
  endtask

  task automatic test_reset();
    logic rdy, we_n, oe_n; logic [17:0] ad; logic [15:0] wd; logic [31:0] rd;
    #12;
    for (int i = 0; i < 2; i++) begin
      sample(i, rdy, we_n, oe_n, ad, wd, rd);
      n_tests++;
      if (rdy !== 1'b1 || we_n !== 1'b1 || oe_n !== 1'b1 || ad !== 18'h0 || wd !== 16'h0 || rd !== 32'h0) begin
        n_fail++;
        $display("FAIL reset inst%0d: ready=%b we_n=%b oe_n=%b addr=%h wdata=%h readData=%h, expected 1/1/1/0/0/0",
                 i, rdy, we_n, oe_n, ad, wd, rd);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle();
    logic rdy, we_n, oe_n; logic [17:0] ad; logic [15:0] wd; logic [31:0] rd;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      sample(0, rdy, we_n, oe_n, ad, wd, rd);
      n_tests++;
      if (rdy !== 1'b1 || we_n !== 1'b1 || oe_n !== 1'b1 || rd !== exp_rd[0]) begin
        n_fail++;
        $display("FAIL idle cycle%0d: ready=%b we_n=%b oe_n=%b readData=%h, expected 1/1/1/%h",
                 c, rdy, we_n, oe_n, rd, exp_rd[0]);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    logic rdy, we_n, oe_n; logic [17:0] ad; logic [15:0] wd; logic [31:0] rd;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h0000_0040, 32'h1111_2222);
    for (int c = 1; c <= 3; c++) @(negedge clk);
    sample(0, rdy, we_n, oe_n, ad, wd, rd);
    n_tests++;
    if (we_n !== 1'b0 || ad !== 18'h00021) begin
      n_fail++;
      $display("FAIL rst_mid pre: we_n=%b addr=%h, expected 0/00021", we_n, ad);
    end
    rst = 1'b0;
    #1;
    sample(0, rdy, we_n, oe_n, ad, wd, rd);
    n_tests++;
    if (we_n !== 1'b1 || oe_n !== 1'b1 || ad !== 18'h0 || wd !== 16'h0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid force: we_n=%b oe_n=%b addr=%h wdata=%h readData=%h, expected 1/1/0/0/0",
               we_n, oe_n, ad, wd, rd);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      sample(0, rdy, we_n, oe_n, ad, wd, rd);
      n_tests++;
      if (rdy !== 1'b1 || we_n !== 1'b1 || oe_n !== 1'b1 || rd !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_mid after cycle%0d: ready=%b we_n=%b oe_n=%b readData=%h, expected 1/1/1/0",
                 c, rdy, we_n, oe_n, rd);
      end
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    test_reset();
    run_access(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, "store_w1");
    run_access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b0, "load_w1");
    run_access(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, "both_en");
    run_access(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 1'b0, "load_after_both");
    run_access(0, 1'b0, 1'b1, 32'h0000_0024, 32'hA5A5_0F0F, 1'b1, 1'b0, "b2b_store_w1");
    run_access(0, 1'b1, 1'b0, 32'h0000_0024, 32'h0,         1'b0, 1'b0, "b2b_load_w1");
    run_access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, "flip_en");
    test_idle();
    run_access(1, 1'b0, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 1'b0, 1'b0, "store_w0");
    run_access(1, 1'b1, 1'b0, 32'h0000_0030, 32'h0,         1'b1, 1'b0, "b2b_load0_w0");
    run_access(1, 1'b1, 1'b0, 32'h0000_0030, 32'h0,         1'b0, 1'b0, "b2b_load1_w0");
    test_reset_mid_store();
    run_access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b0, "load_after_rst");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_controller.md
MEM_ACCESS_CONTROLLER -- requirements
Module: mem_access_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra SRAM wait cycles per 16-bit phase, legal range 0..7.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 MEM_R_EN  input  1  MEM-stage load request, held stable while ready=0.
REQ-005 MEM_W_EN  input  1  MEM-stage store request, held stable while ready=0.
REQ-006 address  input  32  byte address; bits [17:2] select the 32-bit word.
REQ-007 writeData  input  32  store data, held stable while ready=0.
REQ-008 readData  output  32  load result, registered.
REQ-009 ready  output  1  access complete or no access pending; the pipeline drives Freeze = ~ready.
REQ-010 sram_addr  output  18  SRAM halfword address.
REQ-011 sram_wdata  output  16  SRAM write data.
REQ-012 sram_rdata  input  16  SRAM read data.
REQ-013 sram_we_n  output  1  SRAM write strobe, active-low.
REQ-014 sram_oe_n  output  1  SRAM output enable, active-low.

Function
REQ-015 States SHALL be IDLE, LO, HI, DONE.
REQ-016 IDLE: if MEM_W_EN or MEM_R_EN is 1, go to LO next cycle; otherwise stay in IDLE.
REQ-017 When both enables are 1, SHALL perform a write and suppress the read.
REQ-018 ready SHALL be combinational: 1 in DONE, 1 in IDLE with both enables 0, 0 otherwise; it goes low in the request cycle.
REQ-019 LO and HI SHALL each last WAIT_CYCLES+1 cycles, timed by a phase counter that clears on each phase entry.
REQ-020 LO: sram_addr = {address[17:2],1'b0}; a write drives sram_wdata = writeData[15:0] with sram_we_n=0.
REQ-021 HI: sram_addr = {address[17:2],1'b1}; a write drives sram_wdata = writeData[31:16] with sram_we_n=0.
REQ-022 A read drives sram_oe_n=0 during LO and HI.
REQ-023 A read SHALL capture sram_rdata into readData[15:0] on the last LO cycle and into readData[31:16] on the last HI cycle.
REQ-024 sram_we_n and sram_oe_n SHALL be 1 in IDLE and DONE.
REQ-025 sram_addr and sram_wdata SHALL be 0 in IDLE and DONE.
REQ-026 DONE lasts exactly one cycle and always returns to IDLE, even if the enables are still asserted.
REQ-027 Latency: a request seen in IDLE at cycle 0 gives ready=1 at cycle 1+2*(WAIT_CYCLES+1).
REQ-028 A write SHALL leave readData unchanged.
REQ-029 readData SHALL remain stable from DONE until the next read capture.
REQ-030 Back-to-back accesses SHALL have exactly one IDLE cycle between DONE and the next LO.
REQ-031 Enable changes while in LO or HI are a protocol violation; the access in progress SHALL still complete with the latched operation type.

Reset
REQ-032 rst=0 SHALL immediately force: state IDLE, phase counter 0, readData 0, sram_we_n=1, sram_oe_n=1, sram_addr 0, sram_wdata 0.
REQ-033 Reset mid-access SHALL abort the access with no further strobes; ready=1 after release if the enables are 0.

Structure
REQ-034 The state enum, the WAIT_CYCLES default and the 18-bit SRAM address width constant SHALL live in the shared package mem_ctrl_pkg.
REQ-035 The phase counter SHALL be one sub-module, wait_counter, with clear, enable and done outputs.

Verification
REQ-036 Store addr 0x0000_0010, data 0xDEAD_BEEF, WAIT=1 -> we_n low cycles 1-2 with addr 0x00008/wdata 0xBEEF, cycles 3-4 with addr 0x00009/wdata 0xDEAD; ready=1 at cycle 5.
REQ-037 Load addr 0x10, SRAM returns 0xBEEF then 0xDEAD -> readData=0xDEAD_BEEF at DONE, ready low for cycles 0-4.
REQ-038 WAIT=0, load -> ready=1 at cycle 3; two consecutive loads -> exactly one IDLE cycle between them.
REQ-039 MEM_R_EN=MEM_W_EN=1 -> write performed, oe_n never low, readData unchanged.
REQ-040 rst asserted at cycle 3 of a store -> we_n=1 immediately; state IDLE; ready=1 with the enables 0.
REQ-041 Enables 0 for 10 cycles -> ready stays 1, strobes stay inactive, readData holds its value.
